ads127l01_fsync_rx: RTL and testbench

ADS127L01_FSYNC_RX -- requirements
Module: ads127l01_fsync_rx

---
 rtl/ads127l01_fsync_rx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ads127l01_fsync_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads127l01_fsync_rx.sv
// rtl/ads127l01_fsync_rx.sv - ADS127L01 frame-sync serial receiver with sample FIFO
//
// Captures 24-bit two's-complement samples from an ADS127L01 running in
// frame-sync mode. sck, dout and fsync are asynchronous to aclk and are
// oversampled. A rising fsync opens a frame, 24 sck rising edges shift dout
// in MSB first, and the finished word is pushed into a first-word fall-through
// FIFO that a register slave drains.
//
// Optional feature: define ADS_RX_FRAME_CNT_EN to add the frame_cnt output.
//
// Ports:
//   aclk      in   system clock
//   areset    in   asynchronous active-high reset
//   en        in   receive enable; low abandons the current frame silently
//   sck       in   ADC serial clock (asynchronous)
//   dout      in   ADC serial data, MSB first (asynchronous)
//   fsync     in   ADC frame sync, rising edge starts a frame (asynchronous)
//   m_tdata   out  head sample of the FIFO, 0 when empty
//   m_tvalid  out  FIFO not empty
//   m_tready  in   pop strobe, acts when m_tvalid is high
//   clr       in   one-cycle pulse clearing the sticky flags
//   overflow  out  sticky, a finished sample was dropped on a full FIFO
//   frame_err out  sticky, a frame was cut short by a new fsync
//   frame_cnt out  (ADS_RX_FRAME_CNT_EN only) completed frames, wrapping

module ads127l01_fsync_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  input  logic        sck,
  input  logic        dout,
  input  logic        fsync,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  input  logic        clr,
  output logic        overflow,
  output logic        frame_err
`ifdef ADS_RX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] dout_sync_q;
  logic [SYNC_STAGES-1:0] fsync_sync_q;
  logic                   sck_last_q;
  logic                   fsync_last_q;
  logic                   sck_rise;
  logic                   fsync_rise;
  logic                   dout_s;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sck_sync_q   <= '0;
      dout_sync_q  <= '0;
      fsync_sync_q <= '0;
      sck_last_q   <= 1'b0;
      fsync_last_q <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      dout_sync_q  <= {dout_sync_q[SYNC_STAGES-2:0], dout};
      fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], fsync};
      sck_last_q   <= sck_sync_q[SYNC_STAGES-1];
      fsync_last_q <= fsync_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise   = sck_sync_q[SYNC_STAGES-1] & ~sck_last_q;
  assign fsync_rise = fsync_sync_q[SYNC_STAGES-1] & ~fsync_last_q;
  // dout travels through the same number of stages as sck, so the level seen
  // alongside sck_rise is the bit the ADC presented at that sck edge.
  assign dout_s     = dout_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic        push_req;
  logic        ferr_set;
  logic        start;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        start = en & fsync_rise;
      end
      SHIFT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (fsync_rise) begin
          // A new frame arrived before 24 bits: drop the partial word.
          start    = 1'b1;
          ferr_set = 1'b1;
        end else if (sck_rise) begin
          shreg_d   = {shreg_q[22:0], dout_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        push_req = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame start; an sck edge coinciding with fsync is bit 0 of the new frame.
    if (start) begin
      state_d = SHIFT;
      if (sck_rise) begin
        bit_cnt_d = 5'd1;
        shreg_d   = {23'd0, dout_s};
      end else begin
        bit_cnt_d = 5'd0;
        shreg_d   = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_set;

  assign m_tvalid = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = m_tvalid & m_tready;
  // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : 24'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: m_tdata is masked while the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags; a set event in the clr cycle keeps the flag high
  // ---------------------------------------------------------------------------
  logic overflow_q, overflow_d;
  logic frame_err_q, frame_err_d;

  always_comb begin
    overflow_d  = (overflow_q & ~clr) | ovf_set;
    frame_err_d = (frame_err_q & ~clr) | ferr_set;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

`ifdef ADS_RX_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Completed-frame counter; PUSH is entered once per complete frame, whether
  // or not the FIFO accepts the word.
  // ---------------------------------------------------------------------------
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == PUSH) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ads127l01_fsync_rx.sv
// tb/tb_ads127l01_fsync_rx.sv - self-checking bench for ads127l01_fsync_rx
module tb_ads127l01_fsync_rx;

  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HB          = 3;  // aclk cycles per sck half period

  logic        aclk     = 1'b0;
  logic        areset   = 1'b1;
  logic        en       = 1'b0;
  logic        sck      = 1'b0;
  logic        dout     = 1'b0;
  logic        fsync    = 1'b0;
  logic        m_tready = 1'b0;
  logic        clr      = 1'b0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        overflow;
  logic        frame_err;
`ifdef ADS_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Protocol-level model: frames are tracked as bit strings, the FIFO as a queue.
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  bit          exp_ovf    = 1'b0;
  bit          exp_ferr   = 1'b0;
  bit          frame_open = 1'b0;
  int          nbits      = 0;
  logic [23:0] acc        = '0;
  int          frames_done = 0;
  int          done_cyc   = 0;
  bit          lat_arm    = 1'b0;
  logic        prev_tvalid = 1'b0;

  ads127l01_fsync_rx #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .en        (en),
    .sck       (sck),
    .dout      (dout),
    .fsync     (fsync),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .clr       (clr),
    .overflow  (overflow),
    .frame_err (frame_err)
`ifdef ADS_RX_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [23:0] e);
    checks++;
    if (idx >= got_q.size()) begin
      failures++;
      $display("FAIL %s: no sample at index %0d expected 0x%06h", name, idx, e);
    end else if (got_q[idx] !== e) begin
      failures++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, got_q[idx], e);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic m_start();
    if (en && !areset) begin
      if (frame_open) exp_ferr = 1'b1;
      frame_open = 1'b1;
      nbits      = 0;
      acc        = '0;
    end
  endtask

  task automatic m_bit(input logic b);
    if (frame_open && en && !areset) begin
      acc = {acc[22:0], b};
      nbits++;
      if (nbits == 24) begin
        frame_open = 1'b0;
        frames_done++;
        done_cyc = cyc;
        if (exp_q.size() == DEPTH && !m_tready) exp_ovf = 1'b1;
        else exp_q.push_back(acc);
      end
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    exp_ovf     = 1'b0;
    exp_ferr    = 1'b0;
    frame_open  = 1'b0;
    frames_done = 0;
  endtask

  task automatic set_en(input logic v);
    en = v;
    if (!v) frame_open = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    tick();
    clr = 1'b0;
    tick();
  endtask

  // Drives nb bits of w, MSB first; with_fs raises fsync for bit 0, either
  // during its low phase or (same_edge) together with its sck rise.
  task automatic send_bits(input logic [23:0] w, input int nb, input bit with_fs, input bit same_edge);
    for (int i = 0; i < nb; i++) begin
      dout = w[23-i];
      sck  = 1'b0;
      if (i == 0 && with_fs && !same_edge) begin
        fsync = 1'b1;
        m_start();
      end
      repeat (HB) tick();
      sck = 1'b1;
      if (i == 0 && with_fs && same_edge) begin
        fsync = 1'b1;
        m_start();
      end
      m_bit(w[23-i]);
      repeat (HB) tick();
      if (i == 0) fsync = 1'b0;
    end
    sck = 1'b0;
    repeat (HB) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_tready = 1'b1;
    repeat (8) tick();
    while (m_tvalid && n < 200) begin
      tick();
      n++;
    end
    chk("drain_tvalid", m_tvalid, 0);
    chk("model_empty", exp_q.size(), 0);
  endtask

  // Compare process: every pop must deliver the model's head sample.
  always @(negedge aclk) begin
    if (!areset) begin
      if (lat_arm && m_tvalid && !prev_tvalid) begin
        chk("latency", cyc - done_cyc, SYNC_STAGES + 2);
        lat_arm = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_data: got 0x%06h expected no sample", m_tdata);
        end else begin
          if (m_tdata !== exp_q[0]) begin
            failures++;
            $display("FAIL pop_data: got 0x%06h expected 0x%06h", m_tdata, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got_q.push_back(m_tdata);
      end
    end
    prev_tvalid = m_tvalid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
`ifdef ADS_RX_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    areset = 1'b0;
    set_en(1'b1);
    tick();

    // One positive full-scale frame, consumer always ready
    m_tready = 1'b1;
    got_q.delete();
    send_bits(24'h7FFFFF, 24, 1'b1, 1'b0);
    drain();
    chk("s1_count", got_q.size(), 1);
    check_got("s1_data", 0, 24'h7FFFFF);
    chk("s1_overflow", overflow, 0);
    chk("s1_frame_err", frame_err, 0);

    // Three frames buffered, then drained in order
    m_tready = 1'b0;
    got_q.delete();
    lat_arm = 1'b1;
    send_bits(24'h800000, 24, 1'b1, 1'b0);
    send_bits(24'h000001, 24, 1'b1, 1'b0);
    send_bits(24'hABCDEF, 24, 1'b1, 1'b0);
    chk("s2_tvalid", m_tvalid, 1);
    chk("s2_no_pop", got_q.size(), 0);
    drain();
    chk("s2_count", got_q.size(), 3);
    check_got("s2_data0", 0, 24'h800000);
    check_got("s2_data1", 1, 24'h000001);
    check_got("s2_data2", 2, 24'hABCDEF);

    // Six frames into a four-deep FIFO
    m_tready = 1'b0;
    got_q.delete();
    for (int i = 1; i <= 6; i++) begin
      send_bits(24'h111111 * i, 24, 1'b1, 1'b0);
    end
    chk("s3_overflow_model", overflow, exp_ovf);
    chk("s3_overflow", overflow, 1);
    chk("s3_frame_err", frame_err, 0);
    pulse_clr();
    chk("s3_overflow_clr", overflow, 0);
    chk("s3_tvalid_kept", m_tvalid, 1);
    drain();
    chk("s3_count", got_q.size(), 4);
    check_got("s3_data0", 0, 24'h111111);
    check_got("s3_data1", 1, 24'h222222);
    check_got("s3_data2", 2, 24'h333333);
    check_got("s3_data3", 3, 24'h444444);

    // Frame truncated after 10 bits by a new fsync
    got_q.delete();
    send_bits(24'hFFFFFF, 10, 1'b1, 1'b0);
    send_bits(24'h123456, 24, 1'b1, 1'b0);
    drain();
    chk("s4_frame_err_model", frame_err, exp_ferr);
    chk("s4_frame_err", frame_err, 1);
    chk("s4_count", got_q.size(), 1);
    check_got("s4_data", 0, 24'h123456);
    pulse_clr();
    chk("s4_frame_err_clr", frame_err, 0);

    // Enable dropped at bit 12, restored before the next frame
    got_q.delete();
    send_bits(24'h3C3C3C, 12, 1'b1, 1'b0);
    set_en(1'b0);
    repeat (4) tick();
    set_en(1'b1);
    tick();
    chk("s5_no_sample", m_tvalid, 0);
    send_bits(24'h5A5A5A, 24, 1'b1, 1'b0);
    drain();
    chk("s5_frame_err", frame_err, 0);
    chk("s5_count", got_q.size(), 1);
    check_got("s5_data", 0, 24'h5A5A5A);

    // fsync and the first sck edge together
    got_q.delete();
    send_bits(24'hC3C3C3, 24, 1'b1, 1'b1);
    drain();
    chk("s7_frame_err", frame_err, 0);
    chk("s7_count", got_q.size(), 1);
    check_got("s7_data", 0, 24'hC3C3C3);

    // Reset in the middle of a frame
    m_tready = 1'b0;
    got_q.delete();
    send_bits(24'h0F0F0F, 5, 1'b1, 1'b0);
    send_bits(24'h111111, 24, 1'b1, 1'b0);
    send_bits(24'h00FF00, 10, 1'b1, 1'b0);
    chk("s6_pre_tvalid", m_tvalid, 1);
    chk("s6_pre_frame_err", frame_err, 1);
    areset = 1'b1;
    m_reset();
    #1;
    chk("s6_rst_tdata", m_tdata, 0);
    chk("s6_rst_tvalid", m_tvalid, 0);
    chk("s6_rst_overflow", overflow, 0);
    chk("s6_rst_frame_err", frame_err, 0);
    tick();
    tick();
    areset = 1'b0;
    send_bits(24'hFF00FF, 14, 1'b0, 1'b0);
    chk("s6_tail_ignored", m_tvalid, 0);
    send_bits(24'h00FF00, 24, 1'b1, 1'b0);
    drain();
    chk("s6_frame_err", frame_err, 0);
    chk("s6_count", got_q.size(), 1);
    check_got("s6_data", 0, 24'h00FF00);
`ifdef ADS_RX_FRAME_CNT_EN
    chk("s6_frame_cnt_model", frame_cnt, frames_done);
    chk("s6_frame_cnt", frame_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
